// File: rtl/rng_stream_sink.sv
// rng_stream_sink: AXI-Stream sink for the TRNG word stream. Per armed packet it counts
// bytes, sums words, popcounts ones and checks that TLAST lands on the programmed length.
module rng_stream_sink #(
  parameter int PHASES = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       S_AXIS_TDATA,
  input  logic              S_AXIS_TLAST,
  input  logic              S_AXIS_TVALID,
  output logic              S_AXIS_TREADY,
  input  logic              START,
  input  logic              ABORT,
  input  logic [31:0]       EXP_BYTES,
  input  logic [PHASES-1:0] READY_PATTERN,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR_EARLY_LAST,
  output logic              ERR_NO_LAST,
  output logic [31:0]       RCVD_BYTES,
  output logic [31:0]       SUM_DATA,
  output logic [31:0]       ONES_COUNT
);

  localparam int PW = (PHASES > 1) ? $clog2(PHASES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   exp_q, exp_d;
  logic [31:0]   rcvd_q, rcvd_d;
  logic [31:0]   sum_q, sum_d;
  logic [31:0]   ones_q, ones_d;
  logic [5:0]    pop_q, pop_d;
  logic          pop_vld_q, pop_vld_d;
  logic          early_q, early_d;
  logic          nolast_q, nolast_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          tready_q, tready_d;
  logic [PW-1:0] phase_q, phase_d;

  logic          beat;
  logic          arm;
  logic [31:0]   rcvd_next;
  logic [31:0]   arm_len;

  function automatic logic [5:0] popcount32(input logic [31:0] w);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'd0, w[i]};
    end
    return n;
  endfunction

  always_comb begin
    beat      = (state_q == S_RECV) && S_AXIS_TVALID && tready_q;
    rcvd_next = rcvd_q + 32'd4;
    arm_len   = EXP_BYTES & 32'hFFFF_FFFC;
    arm       = START && !ABORT && ((state_q == S_IDLE) || (state_q == S_DONE));

    state_d   = state_q;
    exp_d     = exp_q;
    rcvd_d    = rcvd_q;
    sum_d     = sum_q;
    ones_d    = ones_q;
    pop_d     = pop_q;
    pop_vld_d = beat;
    early_d   = early_q;
    nolast_d  = nolast_q;
    done_d    = done_q;
    phase_d   = phase_q;

    if (beat) begin
      rcvd_d = rcvd_next;
      sum_d  = sum_q + S_AXIS_TDATA;
      pop_d  = popcount32(S_AXIS_TDATA);
    end

    // Popcount of a beat is folded in one cycle after the beat to keep the adder chain short.
    if (pop_vld_q) begin
      ones_d = ones_q + {26'd0, pop_q};
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (arm) begin
          exp_d     = arm_len;
          rcvd_d    = '0;
          sum_d     = '0;
          ones_d    = '0;
          pop_vld_d = 1'b0;
          early_d   = 1'b0;
          nolast_d  = 1'b0;
          phase_d   = '0;
          done_d    = (arm_len == 32'd0);
          state_d   = (arm_len == 32'd0) ? S_DONE : S_RECV;
        end
      end
      S_RECV: begin
        phase_d = (phase_q == PW'(PHASES - 1)) ? '0 : phase_q + 1'b1;
        if (beat) begin
          if (rcvd_next == exp_q) begin
            nolast_d = !S_AXIS_TLAST;
            state_d  = S_DRAIN;
          end else if (S_AXIS_TLAST) begin
            early_d = 1'b1;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (ABORT) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end

    busy_d   = (state_d == S_RECV) || (state_d == S_DRAIN);
    tready_d = (state_d == S_RECV) && READY_PATTERN[phase_d];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      exp_q     <= '0;
      rcvd_q    <= '0;
      sum_q     <= '0;
      ones_q    <= '0;
      pop_q     <= '0;
      pop_vld_q <= 1'b0;
      early_q   <= 1'b0;
      nolast_q  <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      tready_q  <= 1'b0;
      phase_q   <= '0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      rcvd_q    <= rcvd_d;
      sum_q     <= sum_d;
      ones_q    <= ones_d;
      pop_q     <= pop_d;
      pop_vld_q <= pop_vld_d;
      early_q   <= early_d;
      nolast_q  <= nolast_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      tready_q  <= tready_d;
      phase_q   <= phase_d;
    end
  end

  assign S_AXIS_TREADY  = tready_q;
  assign BUSY           = busy_q;
  assign DONE           = done_q;
  assign ERR_EARLY_LAST = early_q;
  assign ERR_NO_LAST    = nolast_q;
  assign RCVD_BYTES     = rcvd_q;
  assign SUM_DATA       = sum_q;
  assign ONES_COUNT     = ones_q;

endmodule

// File: tb/tb_rng_stream_sink.sv
// tb_rng_stream_sink: table-driven directed packets, hand sequences for abort/reset/re-arm,
// and randomized packets checked against a per-packet reference model.
module tb_rng_stream_sink;

  logic        CLK;
  logic        RST;
  logic [31:0] S_AXIS_TDATA;
  logic        S_AXIS_TLAST;
  logic        S_AXIS_TVALID;
  logic        S_AXIS_TREADY;
  logic        START;
  logic        ABORT;
  logic [31:0] EXP_BYTES;
  logic [7:0]  READY_PATTERN;
  logic        BUSY;
  logic        DONE;
  logic        ERR_EARLY_LAST;
  logic        ERR_NO_LAST;
  logic [31:0] RCVD_BYTES;
  logic [31:0] SUM_DATA;
  logic [31:0] ONES_COUNT;

  int compared;
  int mismatched;

  logic [31:0] tx_data[$];
  logic        tx_last[$];

  typedef struct {
    logic [31:0]      exp_bytes;
    logic [7:0]       pattern;
    int               n_words;
    logic [0:7][31:0] words;
    logic [0:7]       lasts;
    logic [31:0]      e_rcvd;
    logic [31:0]      e_sum;
    logic [31:0]      e_ones;
    logic             e_early;
    logic             e_nolast;
    int               e_beats;
    int               e_cycles;
  } vec_t;

  vec_t vecs[9];

  rng_stream_sink #(.PHASES(8)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .S_AXIS_TDATA   (S_AXIS_TDATA),
    .S_AXIS_TLAST   (S_AXIS_TLAST),
    .S_AXIS_TVALID  (S_AXIS_TVALID),
    .S_AXIS_TREADY  (S_AXIS_TREADY),
    .START          (START),
    .ABORT          (ABORT),
    .EXP_BYTES      (EXP_BYTES),
    .READY_PATTERN  (READY_PATTERN),
    .BUSY           (BUSY),
    .DONE           (DONE),
    .ERR_EARLY_LAST (ERR_EARLY_LAST),
    .ERR_NO_LAST    (ERR_NO_LAST),
    .RCVD_BYTES     (RCVD_BYTES),
    .SUM_DATA       (SUM_DATA),
    .ONES_COUNT     (ONES_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
    end
  endtask

  task automatic pulseStart(input logic [31:0] exp_bytes, input logic [7:0] pattern);
    EXP_BYTES     = exp_bytes;
    READY_PATTERN = pattern;
    START         = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  // Holds one word valid until the sink takes it; leaves at a negedge with TVALID low.
  task automatic driveBeat(input logic [31:0] data, input logic last);
    int n = 0;
    S_AXIS_TVALID = 1'b1;
    S_AXIS_TDATA  = data;
    S_AXIS_TLAST  = last;
    while (!S_AXIS_TREADY && n < 20) begin
      @(negedge CLK);
      n++;
    end
    @(negedge CLK);
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
    checkOutput("beat_accepted", 32'(n < 20), 32'd1);
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    while (!DONE && n < 50) begin
      @(negedge CLK);
      n++;
    end
    checkOutput(name, 32'(DONE), 32'd1);
  endtask

  // Arms a packet and streams tx_data/tx_last until DONE; TVALID stays up until a word is taken.
  task automatic applyStimulus(input logic [31:0] exp_bytes, input logic [7:0] pattern,
                               input int valid_pct, output int beats, output int cycles,
                               output logic timed_out);
    int   idx  = 0;
    logic took = 1'b0;
    beats     = 0;
    cycles    = 0;
    timed_out = 1'b0;
    pulseStart(exp_bytes, pattern);
    while (!DONE) begin
      if (cycles >= 400) begin
        timed_out = 1'b1;
        break;
      end
      if (!S_AXIS_TVALID || took) begin
        if (idx < tx_data.size() && int'($urandom_range(99)) < valid_pct) begin
          S_AXIS_TVALID = 1'b1;
          S_AXIS_TDATA  = tx_data[idx];
          S_AXIS_TLAST  = tx_last[idx];
        end else begin
          S_AXIS_TVALID = 1'b0;
          S_AXIS_TDATA  = $urandom;
          S_AXIS_TLAST  = 1'($urandom_range(1));
        end
      end
      took = S_AXIS_TVALID && S_AXIS_TREADY;
      @(negedge CLK);
      cycles++;
      if (took) begin
        idx++;
        beats++;
      end
    end
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
  endtask

  // Reference: walk the offered words, stop at the first one that reaches the length or carries TLAST.
  task automatic modelPacket(input logic [31:0] exp_bytes, output logic [31:0] rcvd,
                             output logic [31:0] sum, output logic [31:0] ones,
                             output logic early, output logic nolast, output int beats);
    logic [31:0] len;
    len    = {exp_bytes[31:2], 2'b00};
    rcvd   = 0;
    sum    = 0;
    ones   = 0;
    early  = 1'b0;
    nolast = 1'b0;
    beats  = 0;
    if (len != 0) begin
      for (int k = 0; k < tx_data.size(); k++) begin
        rcvd  = rcvd + 4;
        sum   = sum + tx_data[k];
        ones  = ones + 32'($countones(tx_data[k]));
        beats = beats + 1;
        if (rcvd == len) begin
          nolast = !tx_last[k];
          break;
        end
        if (tx_last[k]) begin
          early = 1'b1;
          break;
        end
      end
    end
  endtask

  task automatic checkFinal(input logic [31:0] e_rcvd, input logic [31:0] e_sum,
                            input logic [31:0] e_ones, input logic e_early, input logic e_nolast);
    checkOutput("rcvd_bytes", RCVD_BYTES, e_rcvd);
    checkOutput("sum_data", SUM_DATA, e_sum);
    checkOutput("ones_count", ONES_COUNT, e_ones);
    checkOutput("err_early_last", 32'(ERR_EARLY_LAST), 32'(e_early));
    checkOutput("err_no_last", 32'(ERR_NO_LAST), 32'(e_nolast));
    checkOutput("done", 32'(DONE), 32'd1);
    checkOutput("busy_at_done", 32'(BUSY), 32'd0);
    checkOutput("tready_at_done", 32'(S_AXIS_TREADY), 32'd0);
  endtask

  initial begin
    int          beats;
    int          cycles;
    logic        timed_out;
    logic [31:0] m_rcvd, m_sum, m_ones;
    logic        m_early, m_nolast;
    int          m_beats;

    compared      = 0;
    mismatched    = 0;
    RST           = 1'b1;
    S_AXIS_TDATA  = '0;
    S_AXIS_TLAST  = 1'b0;
    S_AXIS_TVALID = 1'b0;
    START         = 1'b0;
    ABORT         = 1'b0;
    EXP_BYTES     = '0;
    READY_PATTERN = 8'hFF;

    vecs[0] = '{32'd16, 8'hFF, 4, {32'h1, 32'h3, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
                8'b0001_0000, 32'd16, 32'h3, 32'd35, 1'b0, 1'b0, 4, 5};
    vecs[1] = '{32'd16, 8'hFF, 4, {32'h10, 32'h20, 32'h30, 32'h40, 32'h0, 32'h0, 32'h0, 32'h0},
                8'b0100_0000, 32'd8, 32'h30, 32'd2, 1'b1, 1'b0, 2, 3};
    vecs[2] = '{32'd8, 8'hFF, 3, {32'hFFFF_0000, 32'h0000_FFFF, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
                8'b0000_0000, 32'd8, 32'hFFFF_FFFF, 32'd32, 1'b0, 1'b1, 2, 3};
    vecs[3] = '{32'd32, 8'h55, 8, {32'h8000_0000, 32'h8000_0000, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h1, 32'h2, 32'h3, 32'h4},
                8'b0000_0001, 32'd32, 32'h9, 32'd39, 1'b0, 1'b0, 8, 16};
    vecs[4] = '{32'd32, 8'hFF, 8, {32'h8000_0000, 32'h8000_0000, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h1, 32'h2, 32'h3, 32'h4},
                8'b0000_0001, 32'd32, 32'h9, 32'd39, 1'b0, 1'b0, 8, 9};
    vecs[5] = '{32'd3, 8'hFF, 1, {32'hDEAD, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
                8'b1000_0000, 32'd0, 32'h0, 32'd0, 1'b0, 1'b0, 0, 0};
    vecs[6] = '{32'h13, 8'hFF, 4, {32'hAAAA_AAAA, 32'h5555_5555, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
                8'b0001_0000, 32'd16, 32'h1234_5677, 32'd45, 1'b0, 1'b0, 4, 5};
    vecs[7] = '{32'd8, 8'hFF, 3, {32'h7, 32'h8, 32'hFFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
                8'b0100_0000, 32'd8, 32'hF, 32'd4, 1'b0, 1'b0, 2, 3};
    vecs[8] = '{32'd12, 8'hFF, 2, {32'hFF00_FF00, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
                8'b1000_0000, 32'd4, 32'hFF00_FF00, 32'd16, 1'b1, 1'b0, 1, 2};

    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    checkOutput("reset_tready", 32'(S_AXIS_TREADY), 32'd0);
    checkOutput("reset_busy", 32'(BUSY), 32'd0);
    checkOutput("reset_done", 32'(DONE), 32'd0);
    checkOutput("reset_early", 32'(ERR_EARLY_LAST), 32'd0);
    checkOutput("reset_nolast", 32'(ERR_NO_LAST), 32'd0);
    checkOutput("reset_rcvd", RCVD_BYTES, 32'd0);
    checkOutput("reset_sum", SUM_DATA, 32'd0);
    checkOutput("reset_ones", ONES_COUNT, 32'd0);

    $display("[TB] directed vector table");
    for (int i = 0; i < 9; i++) begin
      tx_data.delete();
      tx_last.delete();
      for (int k = 0; k < vecs[i].n_words; k++) begin
        tx_data.push_back(vecs[i].words[k]);
        tx_last.push_back(vecs[i].lasts[k]);
      end
      applyStimulus(vecs[i].exp_bytes, vecs[i].pattern, 100, beats, cycles, timed_out);
      checkOutput($sformatf("vec%0d_timeout", i), 32'(timed_out), 32'd0);
      checkFinal(vecs[i].e_rcvd, vecs[i].e_sum, vecs[i].e_ones, vecs[i].e_early, vecs[i].e_nolast);
      checkOutput($sformatf("vec%0d_beats", i), 32'(beats), 32'(vecs[i].e_beats));
      checkOutput($sformatf("vec%0d_cycles", i), 32'(cycles), 32'(vecs[i].e_cycles));
    end

    $display("[TB] START while receiving is ignored");
    pulseStart(32'd16, 8'hFF);
    driveBeat(32'h1, 1'b0);
    driveBeat(32'h2, 1'b0);
    EXP_BYTES = 32'd4;
    START     = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    checkOutput("rearm_rcvd_held", RCVD_BYTES, 32'd8);
    checkOutput("rearm_busy", 32'(BUSY), 32'd1);
    driveBeat(32'h3, 1'b0);
    driveBeat(32'h4, 1'b1);
    waitDone("rearm_done_wait");
    checkFinal(32'd16, 32'd10, 32'd5, 1'b0, 1'b0);

    $display("[TB] ABORT from DONE");
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    checkOutput("abort_done_cleared", 32'(DONE), 32'd0);
    checkOutput("abort_done_rcvd", RCVD_BYTES, 32'd16);

    $display("[TB] ABORT together with START mid-packet");
    pulseStart(32'd32, 8'hFF);
    driveBeat(32'h0000_000F, 1'b0);
    driveBeat(32'h0000_00F0, 1'b0);
    driveBeat(32'h0000_0F00, 1'b0);
    ABORT     = 1'b1;
    START     = 1'b1;
    EXP_BYTES = 32'd8;
    @(negedge CLK);
    ABORT = 1'b0;
    START = 1'b0;
    checkOutput("abort_busy", 32'(BUSY), 32'd0);
    checkOutput("abort_done", 32'(DONE), 32'd0);
    checkOutput("abort_rcvd", RCVD_BYTES, 32'd12);
    checkOutput("abort_sum", SUM_DATA, 32'h0000_0FFF);
    checkOutput("abort_ones", ONES_COUNT, 32'd12);
    checkOutput("abort_tready", 32'(S_AXIS_TREADY), 32'd0);
    S_AXIS_TVALID = 1'b1;
    S_AXIS_TDATA  = 32'hFFFF_FFFF;
    repeat (3) @(negedge CLK);
    S_AXIS_TVALID = 1'b0;
    checkOutput("abort_rcvd_idle", RCVD_BYTES, 32'd12);
    checkOutput("abort_tready_idle", 32'(S_AXIS_TREADY), 32'd0);

    $display("[TB] RST mid-packet");
    pulseStart(32'd32, 8'hFF);
    driveBeat(32'h1234_5678, 1'b0);
    driveBeat(32'hFFFF_0000, 1'b0);
    S_AXIS_TVALID = 1'b1;
    S_AXIS_TDATA  = 32'hFFFF_FFFF;
    RST           = 1'b1;
    @(negedge CLK);
    RST           = 1'b0;
    S_AXIS_TVALID = 1'b0;
    checkOutput("rst_rcvd", RCVD_BYTES, 32'd0);
    checkOutput("rst_sum", SUM_DATA, 32'd0);
    checkOutput("rst_busy", 32'(BUSY), 32'd0);
    checkOutput("rst_tready", 32'(S_AXIS_TREADY), 32'd0);
    @(negedge CLK);
    checkOutput("rst_ones_discarded", ONES_COUNT, 32'd0);
    checkOutput("rst_done", 32'(DONE), 32'd0);

    $display("[TB] randomized packets against reference model");
    for (int p = 0; p < 40; p++) begin
      int          nw;
      logic [31:0] exp_bytes;
      logic [7:0]  pattern;
      nw        = int'($urandom_range(0, 10));
      exp_bytes = (32'(nw) << 2) | 32'($urandom_range(0, 3));
      pattern   = 8'($urandom_range(1, 255));
      tx_data.delete();
      tx_last.delete();
      for (int k = 0; k < nw + 1 + int'($urandom_range(0, 2)); k++) begin
        tx_data.push_back($urandom);
        tx_last.push_back($urandom_range(99) < 15);
      end
      modelPacket(exp_bytes, m_rcvd, m_sum, m_ones, m_early, m_nolast, m_beats);
      applyStimulus(exp_bytes, pattern, 70, beats, cycles, timed_out);
      checkOutput($sformatf("rand%0d_timeout", p), 32'(timed_out), 32'd0);
      checkFinal(m_rcvd, m_sum, m_ones, m_early, m_nolast);
      checkOutput($sformatf("rand%0d_beats", p), 32'(beats), 32'(m_beats));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
